// File: rtl/cla8_seq_ctrl.sv
// Multi-byte adder sequencer: feeds one external 8-bit CLA slice byte by byte,
// LSB first, holding each byte pair for SETTLE cycles and chaining the carry.
module cla8_seq_ctrl #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [8*NBYTES-1:0] a_in,
   input  logic [8*NBYTES-1:0] b_in,
   input  logic                cin,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] sum_out,
   output logic                cout_out,
   output logic                overflow,
   output logic [7:0]          cla_a,
   output logic [7:0]          cla_b,
   output logic                cla_cin,
   input  logic [7:0]          cla_s,
   input  logic                cla_cout
);

   localparam int unsigned W     = 8 * NBYTES;
   localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]     a_q, a_nxt;
   logic [W-1:0]     b_q, b_nxt;
   logic [W-1:0]     sum_nxt;
   logic             carry, carry_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cout_nxt, ovf_nxt;
   logic [7:0]       cla_a_nxt, cla_b_nxt;
   logic             cla_cin_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath next values
   always_comb begin
      state_nxt   = state;
      a_nxt       = a_q;
      b_nxt       = b_q;
      sum_nxt     = sum_out;
      carry_nxt   = carry;
      idx_nxt     = idx;
      cnt_nxt     = cnt;
      cout_nxt    = cout_out;
      ovf_nxt     = overflow;
      cla_a_nxt   = 8'd0;
      cla_b_nxt   = 8'd0;
      cla_cin_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               a_nxt       = a_in;
               b_nxt       = b_in;
               carry_nxt   = cin;
               idx_nxt     = '0;
               cnt_nxt     = CNT_LOAD;
               sum_nxt     = '0;
               cout_nxt    = 1'b0;
               ovf_nxt     = 1'b0;
               cla_a_nxt   = a_in[7:0];
               cla_b_nxt   = b_in[7:0];
               cla_cin_nxt = cin;
               state_nxt   = S_SETTLE;
            end
         end

         S_SETTLE: begin
            cla_a_nxt   = cla_a;
            cla_b_nxt   = cla_b;
            cla_cin_nxt = cla_cin;
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               sum_nxt[8*idx +: 8] = cla_s;
               carry_nxt           = cla_cout;
               if (idx == LAST_IDX) begin
                  cout_nxt    = cla_cout;
                  ovf_nxt     = (a_q[W-1] == b_q[W-1]) && (cla_s[7] != a_q[W-1]);
                  cla_a_nxt   = 8'd0;
                  cla_b_nxt   = 8'd0;
                  cla_cin_nxt = 1'b0;
                  state_nxt   = S_DONE;
               end else begin
                  // Next byte pair goes straight onto the CLA with the fresh carry
                  idx_nxt     = idx + 1'b1;
                  cnt_nxt     = CNT_LOAD;
                  cla_a_nxt   = a_q[8*idx_nxt +: 8];
                  cla_b_nxt   = b_q[8*idx_nxt +: 8];
                  cla_cin_nxt = cla_cout;
               end
            end
         end

         S_DONE: state_nxt = S_IDLE;

         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         sum_out  <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
         cout_out <= 1'b0;
         overflow <= 1'b0;
         cla_a    <= 8'd0;
         cla_b    <= 8'd0;
         cla_cin  <= 1'b0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         a_q      <= a_nxt;
         b_q      <= b_nxt;
         sum_out  <= sum_nxt;
         carry    <= carry_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         cout_out <= cout_nxt;
         overflow <= ovf_nxt;
         cla_a    <= cla_a_nxt;
         cla_b    <= cla_b_nxt;
         cla_cin  <= cla_cin_nxt;
         ready    <= (state_nxt == S_IDLE);
         busy     <= (state_nxt == S_SETTLE);
         done     <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_cla8_seq_ctrl.sv
// Self-checking bench for cla8_seq_ctrl: behavioural CLA slice, arithmetic
// reference model, directed corner cases and randomized operations.
module tb_cla8_seq_ctrl;

   localparam int unsigned NB = 4;
   localparam int unsigned ST = 2;
   localparam int unsigned W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a_in, b_in;
   logic          cin;
   logic          ready, busy, done;
   logic [W-1:0]  sum_out;
   logic          cout_out, overflow;
   logic [7:0]    cla_a, cla_b, cla_s;
   logic          cla_cin, cla_cout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Behavioural stand-in for the gate-level 8-bit CLA
   assign {cla_cout, cla_s} = 9'(cla_a) + 9'(cla_b) + 9'(cla_cin);

   cla8_seq_ctrl #(.NBYTES(NB), .SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .sum_out(sum_out),
      .cout_out(cout_out), .overflow(overflow), .cla_a(cla_a), .cla_b(cla_b),
      .cla_cin(cla_cin), .cla_s(cla_s), .cla_cout(cla_cout)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] x, input int j);
      logic [31:0] s;
      s = x >> (8 * j);
      return s[7:0];
   endfunction

   // Carry into byte j of a+b+c, from plain wide arithmetic
   function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                       input logic c, input int j);
      logic [63:0] m, s;
      if (j == 0) return c;
      m = (64'd1 << (8 * j)) - 64'd1;
      s = (64'(a) & m) + (64'(b) & m) + 64'(c);
      return s[8*j];
   endfunction

   // One operation, start in cycle T; optional stray starts in T+3 and T+9
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit repulse);
      logic [32:0] full;
      logic        ovf;
      int          j;
      full = 33'(a) + 33'(b) + 33'(c);
      ovf  = (a[31] == b[31]) && (full[31] != a[31]);
      @(negedge clk);
      check_eq("ready_before", 64'(ready), 64'd1);
      a_in = a; b_in = b; cin = c; start = 1'b1;
      for (int k = 0; k < int'(NB * ST); k++) begin
         @(negedge clk);
         start = repulse && (k == 2);
         a_in  = $urandom;
         b_in  = $urandom;
         cin   = 1'($urandom_range(0, 1));
         j     = k / int'(ST);
         check_eq("cla_a", 64'(cla_a), 64'(byte_at(a, j)));
         check_eq("cla_b", 64'(cla_b), 64'(byte_at(b, j)));
         check_eq("cla_cin", 64'(cla_cin), 64'(carry_into(a, b, c, j)));
         check_eq("busy", 64'(busy), 64'd1);
         check_eq("ready_busy", 64'(ready), 64'd0);
         check_eq("done_early", 64'(done), 64'd0);
         if (k == 0) begin
            check_eq("sum_cleared", 64'(sum_out), 64'd0);
            check_eq("cout_cleared", 64'(cout_out), 64'd0);
            check_eq("ovf_cleared", 64'(overflow), 64'd0);
         end
      end
      @(negedge clk);
      start = repulse;
      check_eq("done", 64'(done), 64'd1);
      check_eq("busy_done", 64'(busy), 64'd0);
      check_eq("sum", 64'(sum_out), 64'(full[31:0]));
      check_eq("cout", 64'(cout_out), 64'(full[32]));
      check_eq("overflow", 64'(overflow), 64'(ovf));
      check_eq("cla_a_done", 64'({cla_a, cla_b, cla_cin}), 64'd0);
      @(negedge clk);
      start = 1'b0;
      check_eq("done_pulse", 64'(done), 64'd0);
      check_eq("ready_after", 64'(ready), 64'd1);
      check_eq("sum_hold", 64'(sum_out), 64'(full[31:0]));
   endtask

   initial begin
      int d1, d2, nd;
      logic [31:0] ra, rb;
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", 64'(ready), 64'd1);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_sum", 64'(sum_out), 64'd0);
      check_eq("rst_flags", 64'({cout_out, overflow}), 64'd0);
      check_eq("rst_cla", 64'({cla_a, cla_b, cla_cin}), 64'd0);
      rst = 1'b0;

      do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0);
      do_op(32'h12345678, 32'h00000000, 1'b1, 1'b0);
      do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
      do_op(32'h0000FFFF, 32'h00000000, 1'b1, 1'b1);
      do_op(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1);

      // Start held high: back-to-back operations with one IDLE cycle between
      @(negedge clk);
      a_in = 32'h01FF00FF; b_in = 32'h00010001; cin = 1'b1; start = 1'b1;
      d1 = -1; d2 = -1; nd = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (cyc == 20) start = 1'b0;
         if (done) begin
            nd++;
            if (d1 < 0) d1 = cyc; else d2 = cyc;
         end
      end
      check_eq("b2b_count", 64'(nd), 64'd2);
      check_eq("b2b_first", 64'(d1), 64'd9);
      check_eq("b2b_second", 64'(d2), 64'd19);
      check_eq("b2b_sum", 64'(sum_out), 64'h02000101);
      check_eq("b2b_ready", 64'(ready), 64'd1);

      // Reset mid-operation, then a fresh operation
      @(negedge clk);
      a_in = 32'hDEADBEEF; b_in = 32'h11111111; cin = 1'b0; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 4) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check_eq("mrst_ready", 64'(ready), 64'd1);
      check_eq("mrst_busy", 64'(busy), 64'd0);
      check_eq("mrst_done", 64'(done), 64'd0);
      check_eq("mrst_sum", 64'(sum_out), 64'd0);
      check_eq("mrst_cla", 64'({cla_a, cla_b, cla_cin}), 64'd0);
      do_op(32'hDEADBEEF, 32'h11111111, 1'b0, 1'b0);

      // Reset and start together: reset wins
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_eq("rst_start_ready", 64'(ready), 64'd1);
      check_eq("rst_start_busy", 64'(busy), 64'd0);

      for (int n = 0; n < 30; n++) begin
         ra = $urandom;
         rb = $urandom;
         if (n % 5 == 0) rb = ~ra;
         do_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
